// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipelined control unit: opcodes, ALUOp and
// forward-select codes, the decoded control bundle and the per-stage register layouts.
package pipe_ctrl_pkg;

  localparam int OPCODE_W   = 6;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_AND   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic    reg_dst;
    logic    jump;
    logic    branch_eq;
    logic    branch_ne;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Jump is consumed in ID, so the stage registers carry only what later stages need.
  typedef struct packed {
    logic                  reg_dst;
    logic                  alu_src;
    logic                  branch_eq;
    logic                  branch_ne;
    alu_op_e               alu_op;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic                  illegal;
  } id_ex_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] wr_reg;
  } ex_mem_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] wr_reg;
  } mem_wb_t;

  function automatic logic uses_rs(input logic [OPCODE_W-1:0] op);
    return op != OP_J;
  endfunction

  function automatic logic uses_rt(input logic [OPCODE_W-1:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  endfunction

  // The nearer producer (EX/MEM) holds the younger value, so it wins over MEM/WB.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  mem_rw,
    input logic [REG_ADDR_W-1:0] mem_wr,
    input logic                  wb_rw,
    input logic [REG_ADDR_W-1:0] wb_wr
  );
    if (mem_rw && (mem_wr != '0) && (mem_wr == src)) return FWD_MEM;
    if (wb_rw && (wb_wr != '0) && (wb_wr == src))    return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipelined_control_decode.sv
// Combinational main decoder: opcode to control bundle, with an illegal-opcode flag.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_t               ctrl_o,
  output logic                illegal_o
);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl_o    = CTRL_NOP;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      OP_J:   ctrl_o.jump = 1'b1;
      OP_BEQ: begin
        ctrl_o.branch_eq = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_o.branch_ne = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_ANDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_AND;
      end
      OP_LW: begin
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use hazard bubbles, branch flush, EX-stage forwarding selects and a stall counter.
module pipelined_control
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  input  logic                  ext_stall,
  output logic                  id_jump,
  output logic                  hazard_stall,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_branch_eq,
  output logic                  ex_branch_ne,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_wr_reg,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_reg_write,
  output logic                  mem_mem_to_reg,
  output logic [REG_ADDR_W-1:0] mem_wr_reg,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_wr_reg,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      stall_count
);

  ctrl_t            id_ctrl;
  logic             id_illegal;
  id_ex_t           ex_d, ex_q;
  ex_mem_t          mem_d, mem_q;
  mem_wb_t          wb_d, wb_q;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;

  ctrl_decode u_decode (
    .opcode_i  (id_opcode),
    .ctrl_o    (id_ctrl),
    .illegal_o (id_illegal)
  );

  assign id_jump = id_ctrl.jump;

  // A load with a live destination in EX cannot feed an ID consumer in time.
  assign hazard_stall = ex_q.mem_read && (ex_q.wr_reg != '0) &&
                        ((uses_rs(id_opcode) && (ex_q.wr_reg == id_rs)) ||
                         (uses_rt(id_opcode) && (ex_q.wr_reg == id_rt)));

  always_comb begin
    ex_d = '0;
    if (!flush && !hazard_stall) begin
      ex_d.reg_dst    = id_ctrl.reg_dst;
      ex_d.alu_src    = id_ctrl.alu_src;
      ex_d.branch_eq  = id_ctrl.branch_eq;
      ex_d.branch_ne  = id_ctrl.branch_ne;
      ex_d.alu_op     = id_ctrl.alu_op;
      ex_d.mem_read   = id_ctrl.mem_read;
      ex_d.mem_write  = id_ctrl.mem_write;
      ex_d.reg_write  = id_ctrl.reg_write;
      ex_d.mem_to_reg = id_ctrl.mem_to_reg;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.wr_reg     = id_ctrl.reg_dst ? id_rd : id_rt;
      ex_d.illegal    = id_illegal;
    end
  end

  always_comb begin
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.wr_reg     = ex_q.wr_reg;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.mem_to_reg  = mem_q.mem_to_reg;
    wb_d.wr_reg      = mem_q.wr_reg;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (hazard_stall && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else if (!ext_stall) begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_a = fwd_select(ex_q.rs, mem_q.reg_write, mem_q.wr_reg, wb_q.reg_write, wb_q.wr_reg);
  assign fwd_b = fwd_select(ex_q.rt, mem_q.reg_write, mem_q.wr_reg, wb_q.reg_write, wb_q.wr_reg);

  assign ex_reg_dst     = ex_q.reg_dst;
  assign ex_alu_src     = ex_q.alu_src;
  assign ex_branch_eq   = ex_q.branch_eq;
  assign ex_branch_ne   = ex_q.branch_ne;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_wr_reg      = ex_q.wr_reg;
  assign illegal_op     = ex_q.illegal;
  assign mem_mem_read   = mem_q.mem_read;
  assign mem_mem_write  = mem_q.mem_write;
  assign mem_reg_write  = mem_q.reg_write;
  assign mem_mem_to_reg = mem_q.mem_to_reg;
  assign mem_wr_reg     = mem_q.wr_reg;
  assign wb_reg_write   = wb_q.reg_write;
  assign wb_mem_to_reg  = wb_q.mem_to_reg;
  assign wb_wr_reg      = wb_q.wr_reg;
  assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_pipelined_control.sv
// Self-checking bench for pipelined_control: directed scenarios plus a random stream,
// all checked against an instruction-slot model of the three downstream stages.
module tb_pipelined_control;

  localparam int CW = 4;

  localparam logic [5:0] R_OP = 6'b000000, J_OP = 6'b000010, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BAD = 6'b111111;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    id_opcode;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          flush, ext_stall;
  logic          id_jump, hazard_stall;
  logic          ex_reg_dst, ex_alu_src, ex_branch_eq, ex_branch_ne;
  logic [1:0]    ex_alu_op;
  logic [4:0]    ex_wr_reg;
  logic [1:0]    fwd_a, fwd_b;
  logic          mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg;
  logic [4:0]    mem_wr_reg;
  logic          wb_reg_write, wb_mem_to_reg;
  logic [4:0]    wb_wr_reg;
  logic          illegal_op;
  logic [CW-1:0] stall_count;

  pipelined_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .flush(flush), .ext_stall(ext_stall), .id_jump(id_jump),
    .hazard_stall(hazard_stall), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
    .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne), .ex_alu_op(ex_alu_op),
    .ex_wr_reg(ex_wr_reg), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_wr_reg(mem_wr_reg), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_wr_reg(wb_wr_reg), .illegal_op(illegal_op),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // One record per pipeline slot; v=0 is a bubble.
  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
  } rec_t;

  rec_t        m_ex, m_mem, m_wb;
  int unsigned m_cnt;
  logic        m_haz;
  int          total = 0;
  int          bad = 0;

  // Decode table bits: [10]RegDst [9]Jump [8]BEq [7]BNe [6]MRd [5]M2R [4]MWr [3]ALUSrc [2]RWr [1:0]ALUOp
  function automatic logic [10:0] dec(input logic [5:0] op);
    case (op)
      R_OP:    return {9'b1_0_0_0_0_0_0_0_1, 2'b10};
      J_OP:    return {9'b0_1_0_0_0_0_0_0_0, 2'b00};
      BEQ:     return {9'b0_0_1_0_0_0_0_0_0, 2'b01};
      BNE:     return {9'b0_0_0_1_0_0_0_0_0, 2'b01};
      ADDI:    return {9'b0_0_0_0_0_0_0_1_1, 2'b00};
      ANDI:    return {9'b0_0_0_0_0_0_0_1_1, 2'b11};
      LW:      return {9'b0_0_0_0_1_1_0_1_1, 2'b00};
      SW:      return {9'b0_0_0_0_0_0_1_1_0, 2'b00};
      default: return 11'b0;
    endcase
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {R_OP, J_OP, BEQ, BNE, ADDI, ANDI, LW, SW};
  endfunction

  function automatic logic [10:0] cb(input rec_t r);
    return r.v ? dec(r.op) : 11'b0;
  endfunction

  function automatic logic [4:0] wr(input rec_t r);
    logic [10:0] c;
    c = dec(r.op);
    if (!r.v) return 5'd0;
    return c[10] ? r.rd : r.rt;
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] src);
    logic [10:0] mc, wc;
    mc = cb(m_mem);
    wc = cb(m_wb);
    if (mc[2] && wr(m_mem) != 0 && wr(m_mem) == src) return 2'b10;
    if (wc[2] && wr(m_wb) != 0 && wr(m_wb) == src)   return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_haz();
    logic [10:0] c;
    logic        rs_u, rt_u;
    c    = cb(m_ex);
    rs_u = (id_opcode != J_OP);
    rt_u = id_opcode inside {R_OP, BEQ, BNE, SW};
    return c[6] && wr(m_ex) != 0 &&
           ((rs_u && wr(m_ex) == id_rs) || (rt_u && wr(m_ex) == id_rt));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    logic [10:0] c, mc, wc;
    c  = cb(m_ex);
    mc = cb(m_mem);
    wc = cb(m_wb);
    check("ex_ctrl", {ex_reg_dst, ex_alu_src, ex_branch_eq, ex_branch_ne, ex_alu_op},
          {c[10], c[3], c[8], c[7], c[1:0]});
    check("ex_wr_reg", ex_wr_reg, wr(m_ex));
    check("illegal_op", illegal_op, m_ex.v && !legal(m_ex.op));
    check("fwd_a", fwd_a, fsel(m_ex.rs));
    check("fwd_b", fwd_b, fsel(m_ex.rt));
    check("mem_ctrl", {mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg},
          {mc[6], mc[4], mc[2], mc[5]});
    check("mem_wr_reg", mem_wr_reg, wr(m_mem));
    check("wb_ctrl", {wb_reg_write, wb_mem_to_reg}, {wc[2], wc[5]});
    check("wb_wr_reg", wb_wr_reg, wr(m_wb));
    check("stall_count", stall_count, m_cnt);
  endtask

  task automatic model_clear();
    m_ex  = '0;
    m_mem = '0;
    m_wb  = '0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {id_opcode, id_rs, id_rt, id_rd, flush, ext_stall} = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_out();
    check("hazard_in_reset", hazard_stall, 1'b0);
    reset = 1'b0;
  endtask

  // One clock cycle: drive ID inputs, check combinational outputs, then the edge's results.
  task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic fl, input logic es);
    @(negedge clk);
    id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl; ext_stall = es;
    #1;
    m_haz = exp_haz();
    check("hazard_stall", hazard_stall, m_haz);
    check("id_jump", id_jump, dec(op) >> 9 & 11'd1);
    @(posedge clk);
    if (!es) begin
      if (m_haz && m_cnt != 2**CW - 1) m_cnt++;
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = '0;
      if (!fl && !m_haz) begin
        m_ex.v = 1'b1; m_ex.op = op; m_ex.rs = rs; m_ex.rt = rt; m_ex.rd = rd;
      end
    end
    #1;
    check_out();
  endtask

  task automatic nop();
    step(R_OP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  logic [5:0] ops [9] = '{R_OP, J_OP, BEQ, BNE, ADDI, ANDI, LW, SW, BAD};

  initial begin
    logic [5:0] r_op;
    logic [4:0] r_rs, r_rt, r_rd;
    logic       r_fl, r_es, keep;

    do_reset();

    // Basic R-type latency
    step(R_OP, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    check("t1_alu_op", ex_alu_op, 2'b10);
    check("t1_wr_reg", ex_wr_reg, 5'd3);
    nop();
    nop();
    check("t1_wb_rw", wb_reg_write, 1'b1);
    check("t1_wb_wr", wb_wr_reg, 5'd3);

    // Load-use stall
    step(LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
    step(R_OP, 5'd4, 5'd6, 5'd7, 1'b0, 1'b0);
    check("t2_stall", m_haz, 1'b1);
    check("t2_bubble", {ex_alu_op, ex_wr_reg, ex_alu_src}, 8'd0);
    check("t2_count", stall_count, 1);
    step(R_OP, 5'd4, 5'd6, 5'd7, 1'b0, 1'b0);
    check("t2_no_stall", hazard_stall, 1'b0);
    check("t2_fwd_a", fwd_a, 2'b01);

    // Forwarding from EX/MEM, MEM/WB and the r0 exclusion
    step(R_OP, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
    step(R_OP, 5'd5, 5'd5, 5'd8, 1'b0, 1'b0);
    check("t3_mem_a", fwd_a, 2'b10);
    check("t3_mem_b", fwd_b, 2'b10);
    step(R_OP, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
    nop();
    step(R_OP, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
    check("t3_wb_a", fwd_a, 2'b01);
    check("t3_wb_b", fwd_b, 2'b01);
    step(R_OP, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step(R_OP, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0);
    check("t3_r0_a", fwd_a, 2'b00);

    // Branch flush kills the load in ID
    step(BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step(LW, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0);
    check("t4_ex_bubble", {ex_alu_src, ex_wr_reg}, 6'd0);
    nop();
    check("t4_mem_rd", mem_mem_read, 1'b0);
    nop();
    check("t4_wb_rw", wb_reg_write, 1'b0);

    // Freeze with a pending load-use hazard, then a flush held through a freeze
    step(LW, 5'd1, 5'd6, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(R_OP, 5'd6, 5'd1, 5'd11, 1'b0, 1'b1);
      check("t5_frozen_cnt", stall_count, 1);
    end
    step(R_OP, 5'd6, 5'd1, 5'd11, 1'b0, 1'b0);
    check("t5_cnt", stall_count, 2);
    step(R_OP, 5'd6, 5'd1, 5'd11, 1'b0, 1'b0);
    step(BNE, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0);
    step(ADDI, 5'd2, 5'd7, 5'd0, 1'b1, 1'b1);
    step(ADDI, 5'd2, 5'd7, 5'd0, 1'b1, 1'b1);
    step(ADDI, 5'd2, 5'd7, 5'd0, 1'b1, 1'b0);
    step(J_OP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Illegal opcode, then asynchronous reset between edges
    step(BAD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    check("t6_illegal", illegal_op, 1'b1);
    check("t6_ex_zero", {ex_reg_dst, ex_alu_src, ex_branch_eq, ex_branch_ne, ex_alu_op}, 6'd0);
    nop();
    check("t6_illegal_pulse", illegal_op, 1'b0);
    step(LW, 5'd1, 5'd12, 5'd0, 1'b0, 1'b0);
    check("t6_lw_in_ex", ex_wr_reg, 5'd12);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_out();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      step(LW, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
      step(R_OP, 5'd4, 5'd0, 5'd5, 1'b0, 1'b0);
      step(R_OP, 5'd4, 5'd0, 5'd5, 1'b0, 1'b0);
    end
    check("sat_count", stall_count, 2**CW - 1);

    // Random stream; the ID instruction is held while stalled or frozen
    do_reset();
    keep = 1'b0;
    {r_op, r_rs, r_rt, r_rd, r_fl} = '0;
    for (int i = 0; i < 400; i++) begin
      if (!keep) begin
        r_op = ops[$urandom_range(0, 8)];
        r_rs = 5'($urandom_range(0, 7));
        r_rt = 5'($urandom_range(0, 7));
        r_rd = 5'($urandom_range(0, 7));
        r_fl = ($urandom_range(0, 9) == 0);
      end
      r_es = ($urandom_range(0, 7) == 0);
      step(r_op, r_rs, r_rt, r_rd, r_fl, r_es);
      keep = r_es || (m_haz && !r_fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
